// File: rtl/instmem_loader.sv
// Streams a length-prefixed program image into instruction memory while holding the core.
// Optional trailing checksum byte is enabled with the INSTMEM_LOADER_CHECKSUM_EN macro.
module instmem_loader #(
    parameter int INST_LENGTH = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int N_LOCATIONS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INST_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [INST_LENGTH-1:0] mem_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   core_hold
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
`ifdef INSTMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [INST_LENGTH-1:0] MAX_LEN = INST_LENGTH'(N_LOCATIONS);

    state_t                 state;
    logic [INST_LENGTH-1:0] count;
    logic [INST_LENGTH-1:0] length;
    logic                   hs;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
    logic [INST_LENGTH-1:0] sum;
    logic [INST_LENGTH-1:0] sum_final;

    assign sum_final = sum + in_data;
`endif

    assign hs = in_valid & in_ready;

    // Every output is a register updated together with the state, so in_ready
    // already reflects the state the loader is in during that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b0;
            count     <= '0;
            length    <= '0;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state     <= LEN;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        core_hold <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                LEN: begin
                    if (hs) begin
                        length <= in_data;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                        sum    <= in_data;
`endif
                        if (in_data == '0 || in_data > MAX_LEN) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            count <= '0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (hs) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= count[ADDR_WIDTH-1:0];
                        mem_wdata <= in_data;
                        count     <= count + 1'b1;
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                        sum       <= sum_final;
                        if (count == length - 1'b1) begin
                            state <= CHECK;
                        end
`else
                        if (count == length - 1'b1) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            busy      <= 1'b0;
                            core_hold <= 1'b0;
                            done      <= 1'b1;
                        end
`endif
                    end
                end
`ifdef INSTMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    // Image is good only if length, data and this byte sum to zero mod 2^8.
                    if (hs) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (sum_final == '0) begin
                            state     <= DONE;
                            core_hold <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instmem_loader.sv
// Self-checking bench for instmem_loader: directed and random loads against a byte-stream model.
module tb_instmem_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       mem_we;
   logic [5:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       busy;
   logic       done;
   logic       error;
   logic       core_hold;

   int         checks = 0;
   int         failures = 0;
   int         writes_seen = 0;
   logic [7:0] obs_mem [64];
   logic [7:0] exp_mem [64];
   logic [7:0] stream_q [$];

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   instmem_loader dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .core_hold (core_hold)
   );

   // Record every memory write the DUT issues into a shadow memory
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         writes_seen++;
         obs_mem[mem_addr] = mem_wdata;
      end
   end

   // Hard time limit so a stuck DUT can never hang the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts and reports each check
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance to just after the falling edge, away from the active edge
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // All outputs must be at their reset values
   task automatic checkIdle(input string tag);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_error"}, 32'(error), 32'd0);
      checkOutput({tag, "_core_hold"}, 32'(core_hold), 32'd0);
   endtask

   // Append the byte that makes the whole image sum to zero when checksums are in use
   task automatic appendChecksum();
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      logic [7:0] s;
      s = 8'd0;
      foreach (stream_q[i]) s = s + stream_q[i];
      stream_q.push_back(8'd0 - s);
`endif
   endtask

   // Pulse start, feed stream_q, check every write and the final status.
   // valid_mode: 0 = always valid, 1 = toggle every cycle, 2 = random.
   task automatic applyStimulus(input int valid_mode);
      int         len;
      int         total;
      int         idx;
      int         cycles;
      int         w0;
      logic       bad;
      logic       ok;
      logic       v;
      logic       expw;
      logic [7:0] s;
      len = int'(stream_q[0]);
      bad = (len == 0) || (len > 64);
`ifdef INSTMEM_LOADER_CHECKSUM_EN
      total = bad ? 1 : len + 2;
      ok = 1'b0;
      if (!bad) begin
         s = 8'd0;
         for (int i = 0; i < len + 2; i++) s = s + stream_q[i];
         ok = (s == 8'd0);
      end
`else
      total = bad ? 1 : len + 1;
      ok = !bad;
`endif
      w0 = writes_seen;
      start = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      checkOutput("post_start_busy", 32'(busy), 32'd1);
      checkOutput("post_start_core_hold", 32'(core_hold), 32'd1);
      checkOutput("post_start_done", 32'(done), 32'd0);
      checkOutput("post_start_error", 32'(error), 32'd0);
      idx = 0;
      cycles = 0;
      while (idx < total && cycles < 2000) begin
         checkOutput("load_in_ready", 32'(in_ready), 32'd1);
         case (valid_mode)
            0: v = 1'b1;
            1: v = (cycles % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         in_valid = v;
         in_data = v ? stream_q[idx] : 8'($urandom);
         tick();
         expw = v && !bad && idx >= 1 && idx <= len;
         checkOutput("write_strobe", 32'(mem_we), 32'(expw));
         if (expw) begin
            checkOutput("write_addr", 32'(mem_addr), 32'(idx - 1));
            checkOutput("write_data", 32'(mem_wdata), 32'(stream_q[idx]));
            exp_mem[idx - 1] = stream_q[idx];
         end
         if (v) idx++;
         cycles++;
      end
      checkOutput("bytes_consumed", 32'(idx), 32'(total));
      in_valid = 1'b1;
      in_data = 8'h5A;
      tick();
      in_valid = 1'b0;
      checkOutput("trailing_mem_we", 32'(mem_we), 32'd0);
      checkOutput("trailing_in_ready", 32'(in_ready), 32'd0);
      checkOutput("final_busy", 32'(busy), 32'd0);
      checkOutput("final_done", 32'(done), 32'(ok));
      checkOutput("final_error", 32'(error), 32'(!ok));
      checkOutput("final_core_hold", 32'(core_hold), 32'(!ok));
      checkOutput("write_count", 32'(writes_seen - w0), bad ? 32'd0 : 32'(len));
   endtask

   // Shadow memory must equal the model image, including untouched locations
   task automatic compareMemory();
      for (int i = 0; i < 64; i++) begin
         checkOutput($sformatf("mem_image_%0d", i), 32'(obs_mem[i]), 32'(exp_mem[i]));
      end
   endtask

   initial begin
      int         len;
      int         w0;
      logic [7:0] d [4];
      for (int i = 0; i < 64; i++) begin
         obs_mem[i] = 8'd0;
         exp_mem[i] = 8'd0;
      end
      reset = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 8'd0;
      repeat (3) tick();
      reset = 1'b0;

      $display("[TB] idle after reset");
      for (int i = 0; i < 5; i++) begin
         tick();
         checkIdle("idle");
      end

      $display("[TB] directed three-word load");
      stream_q = '{8'h03, 8'hA1, 8'hB2, 8'hC3};
      appendChecksum();
      applyStimulus(0);

      $display("[TB] bad lengths then recovery");
      stream_q = '{8'h00};
      applyStimulus(0);
      stream_q = '{8'h41};
      applyStimulus(0);
      stream_q = '{8'h02, 8'h11, 8'h22};
      appendChecksum();
      applyStimulus(0);

      $display("[TB] full 64-word load with toggling valid");
      stream_q = '{8'd64};
      for (int i = 0; i < 64; i++) stream_q.push_back(8'($urandom));
      appendChecksum();
      applyStimulus(1);
      compareMemory();

      $display("[TB] random loads");
      for (int n = 0; n < 6; n++) begin
         if (n == 3) len = 0;
         else if (n == 4) len = int'($urandom_range(65, 255));
         else len = int'($urandom_range(1, 64));
         stream_q = '{8'(len)};
         if (len >= 1 && len <= 64) begin
            for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom));
            appendChecksum();
         end
         applyStimulus(2);
      end
      compareMemory();

      $display("[TB] reset during a load");
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      w0 = writes_seen;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'd4;
      tick();
      in_data = d[0];
      tick();
      exp_mem[0] = d[0];
      in_data = d[1];
      tick();
      exp_mem[1] = d[1];
      in_data = d[2];
      reset = 1'b1;
      tick();
      checkIdle("abort");
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
         checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
      end
      in_valid = 1'b0;
      checkOutput("abort_write_count", 32'(writes_seen - w0), 32'd2);
      compareMemory();

`ifdef INSTMEM_LOADER_CHECKSUM_EN
      $display("[TB] checksum pass and fail");
      stream_q = '{8'h02, 8'h10, 8'h20, 8'hCE};
      applyStimulus(0);
      stream_q = '{8'h02, 8'h10, 8'h20, 8'hCF};
      applyStimulus(0);
      compareMemory();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
